// File: rtl/dummy_dispatch_pkg.sv
// dummy_dispatch_pkg: shared types for the dummy coprocessor request front end.
// Rev 1.0
`default_nettype none

package dummy_dispatch_pkg;

  localparam int DUMMY_DATA_W = 32;

  typedef enum logic [1:0] {
    RES_SEL_COMB = 2'b00,
    RES_SEL_PIPE = 2'b01,
    RES_SEL_ITER = 2'b10,
    RES_SEL_ILL  = 2'b11
  } res_sel_t;

  typedef struct packed {
    res_sel_t                sel;
    logic [DUMMY_DATA_W-1:0] data;
  } dispatch_entry_t;

endpackage

`default_nettype wire

// File: rtl/dummy_dispatch_if.sv
// dummy_dispatch_if: request/response channel plus the three unit channels.
// Rev 1.0
`default_nettype none

interface dummy_dispatch_if
  import dummy_dispatch_pkg::*;
#(
  parameter int DATA_W = DUMMY_DATA_W
);

  logic              req_valid_i;
  logic              req_ready_o;
  res_sel_t          req_sel_i;
  logic [DATA_W-1:0] req_a_i;
  logic [DATA_W-1:0] req_b_i;
  logic [DATA_W-1:0] op_a_o;
  logic [DATA_W-1:0] op_b_o;
  logic [DATA_W-1:0] comb_res_i;
  logic              pipe_valid_o;
  logic              pipe_ready_i;
  logic              pipe_res_valid_i;
  logic              pipe_res_ready_o;
  logic [DATA_W-1:0] pipe_res_i;
  logic              iter_valid_o;
  logic              iter_ready_i;
  logic              iter_res_valid_i;
  logic              iter_res_ready_o;
  logic [DATA_W-1:0] iter_res_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [DATA_W-1:0] rsp_data_o;
  logic              rsp_err_o;
  logic              busy_o;

  // Dispatcher view
  modport slave (
    input  req_valid_i, req_sel_i, req_a_i, req_b_i, comb_res_i,
           pipe_ready_i, pipe_res_valid_i, pipe_res_i,
           iter_ready_i, iter_res_valid_i, iter_res_i, rsp_ready_i,
    output req_ready_o, op_a_o, op_b_o, pipe_valid_o, pipe_res_ready_o,
           iter_valid_o, iter_res_ready_o, rsp_valid_o, rsp_data_o,
           rsp_err_o, busy_o
  );

  // Requester and execution-unit view
  modport master (
    output req_valid_i, req_sel_i, req_a_i, req_b_i, comb_res_i,
           pipe_ready_i, pipe_res_valid_i, pipe_res_i,
           iter_ready_i, iter_res_valid_i, iter_res_i, rsp_ready_i,
    input  req_ready_o, op_a_o, op_b_o, pipe_valid_o, pipe_res_ready_o,
           iter_valid_o, iter_res_ready_o, rsp_valid_o, rsp_data_o,
           rsp_err_o, busy_o
  );

endinterface

`default_nettype wire

// File: rtl/dummy_tag_fifo.sv
// dummy_tag_fifo: DEPTH x WIDTH synchronous FIFO with full/empty/count.
// Rev 1.0
`default_nettype none

module dummy_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 34
) (
  input  wire logic                       clk,
  input  wire logic                       rst_n,
  input  wire logic                       push,
  input  wire logic [WIDTH-1:0]           wdata,
  input  wire logic                       pop,
  output logic      [WIDTH-1:0]           rdata,
  output logic                            full,
  output logic                            empty,
  output logic      [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by natural overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/dummy_dispatch.sv
// dummy_dispatch: issues requests to comb/pipe/iter units and returns results in issue order.
// Rev 1.0
`default_nettype none

module dummy_dispatch
  import dummy_dispatch_pkg::*;
#(
  parameter int DATA_W = DUMMY_DATA_W,
  parameter int DEPTH  = 4
) (
  input  wire logic       clk_i,
  input  wire logic       rst_ni,
  dummy_dispatch_if.slave bus
);

  typedef struct packed {
    res_sel_t          sel;
    logic [DATA_W-1:0] data;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);
  localparam int CNT_W   = $clog2(DEPTH+1);

  logic               full;
  logic               empty;
  logic [CNT_W-1:0]   count;
  logic               unit_ready;
  logic               push;
  logic               pop;
  entry_t             push_entry;
  entry_t             head;
  logic [ENTRY_W-1:0] head_bits;

  assign bus.op_a_o = bus.req_a_i;
  assign bus.op_b_o = bus.req_b_i;

  always_comb begin
    case (bus.req_sel_i)
      RES_SEL_PIPE: unit_ready = bus.pipe_ready_i;
      RES_SEL_ITER: unit_ready = bus.iter_ready_i;
      default:      unit_ready = 1'b1;
    endcase
  end

  // rst_ni gates the request side so nothing is offered while in reset
  assign bus.req_ready_o  = rst_ni && !full && unit_ready;
  assign bus.pipe_valid_o = rst_ni && bus.req_valid_i && !full && (bus.req_sel_i == RES_SEL_PIPE);
  assign bus.iter_valid_o = rst_ni && bus.req_valid_i && !full && (bus.req_sel_i == RES_SEL_ITER);
  assign push             = bus.req_valid_i && bus.req_ready_o;

  always_comb begin
    push_entry.sel  = bus.req_sel_i;
    push_entry.data = (bus.req_sel_i == RES_SEL_COMB) ? bus.comb_res_i : '0;
  end

  dummy_tag_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_tag_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head_bits),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign head = entry_t'(head_bits);

  always_comb begin
    bus.rsp_valid_o = 1'b0;
    bus.rsp_data_o  = '0;
    bus.rsp_err_o   = 1'b0;
    if (!empty) begin
      case (head.sel)
        RES_SEL_COMB: begin
          bus.rsp_valid_o = 1'b1;
          bus.rsp_data_o  = head.data;
        end
        RES_SEL_PIPE: begin
          bus.rsp_valid_o = bus.pipe_res_valid_i;
          bus.rsp_data_o  = bus.pipe_res_valid_i ? bus.pipe_res_i : '0;
        end
        RES_SEL_ITER: begin
          bus.rsp_valid_o = bus.iter_res_valid_i;
          bus.rsp_data_o  = bus.iter_res_valid_i ? bus.iter_res_i : '0;
        end
        default: begin
          bus.rsp_valid_o = 1'b1;
          bus.rsp_err_o   = 1'b1;
        end
      endcase
    end
  end

  // Only the head's unit may hand over its result; later ones are held off
  assign bus.pipe_res_ready_o = !empty && (head.sel == RES_SEL_PIPE) && bus.rsp_ready_i;
  assign bus.iter_res_ready_o = !empty && (head.sel == RES_SEL_ITER) && bus.rsp_ready_i;
  assign pop                  = bus.rsp_valid_o && bus.rsp_ready_i;
  assign bus.busy_o           = (count != '0);

endmodule

`default_nettype wire

// File: doc/dummy_dispatch.md
Name: dummy_dispatch

Overview:
- Request-side front end of the dummy coprocessor.
- Accepts operation requests tagged with a res_sel_t unit selector and issues each one to the combinational, pipelined or iterative unit.
- Records issue order in a tag FIFO and returns results to the requester strictly in issue order, with a single valid/ready response channel.
- Combinational results are captured at issue time.
- An illegal selector (2'b11) is accepted and answered with an error response.

Parameters:
- DATA_W, 32, operand/result width.
- DEPTH, 4, tag FIFO entries (max outstanding requests); power of two, >= 2.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready
- req_sel_i  in  2  target unit, res_sel_t
- req_a_i  in  DATA_W  operand A
- req_b_i  in  DATA_W  operand B
- op_a_o  out  DATA_W  operand A to all units (= req_a_i)
- op_b_o  out  DATA_W  operand B to all units (= req_b_i)
- comb_res_i  in  DATA_W  combinational unit result for op_a_o/op_b_o
- pipe_valid_o  out  1  issue to pipelined unit
- pipe_ready_i  in  1  pipelined unit can accept
- pipe_res_valid_i  in  1  pipelined result valid
- pipe_res_ready_o  out  1  pipelined result consumed
- pipe_res_i  in  DATA_W  pipelined result
- iter_valid_o / iter_ready_i / iter_res_valid_i / iter_res_ready_o / iter_res_i: same directions, widths and meanings for the iterative unit
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  requester accepts response
- rsp_data_o  out  DATA_W  result
- rsp_err_o  out  1  illegal selector response
- busy_o  out  1  FIFO non-empty

Behaviour:
- Reset (rst_ni low, asynchronous):
  - FIFO read/write pointers and count cleared.
  - rsp_valid_o, pipe_res_ready_o, iter_res_ready_o and busy_o are 0.
  - pipe_valid_o, iter_valid_o and req_ready_o are 0 (the FIFO is not full, but req_valid_i is gated by reset).
  - Mid-operation reset drops all outstanding entries; the units share rst_ni and drop their own.
- FIFO entry: {sel[1:0], data[DATA_W-1:0]}. data is written only for RES_SEL_COMB, with comb_res_i sampled on the issue cycle.
- Accept condition:
  - req_ready_o = !full && (sel==PIPE ? pipe_ready_i : sel==ITER ? iter_ready_i : 1).
  - Purely combinational from full and the unit readies; no dependence on rsp_ready_i.
- Issue qualifiers: pipe_valid_o = req_valid_i && !full && sel==PIPE; iter_valid_o is the same with ITER. No unit is issued for COMB or illegal selectors.
- Push occurs on req_valid_i && req_ready_o. The entry becomes visible at the head the next cycle; there is no same-cycle bypass.
- When full, req_ready_o=0 even if a pop happens in the same cycle.
- Response path, head entry h, valid only when !empty:
  - COMB: rsp_valid_o=1, rsp_data_o=h.data, rsp_err_o=0.
  - PIPE: rsp_valid_o=pipe_res_valid_i, rsp_data_o=pipe_res_i.
  - ITER: rsp_valid_o=iter_res_valid_i, rsp_data_o=iter_res_i.
  - 2'b11: rsp_valid_o=1, rsp_data_o=0, rsp_err_o=1.
- pipe_res_ready_o = !empty && h.sel==PIPE && rsp_ready_i; iter_res_ready_o is the analogous signal.
- Results not at the head are back-pressured (res_ready=0); units must hold valid/data stable until ready.
- Pop occurs on rsp_valid_o && rsp_ready_i.
- Simultaneous push and pop leaves the count unchanged. Both pointers wrap modulo DEPTH.
- Latency:
  - COMB or illegal request into an empty FIFO: rsp_valid_o asserts 1 cycle after acceptance.
  - PIPE/ITER: max(1, unit latency).
- rsp_data_o is 0 when rsp_valid_o=0. Outputs are stable while rsp_valid_o && !rsp_ready_i.
- busy_o = !empty.

Decomposition:
- In the shared package: res_sel_t, with a new enumerator RES_SEL_ILL=2'b11, and a packed struct dispatch_entry_t {res_sel_t sel; logic [DATA_W-1:0] data}.
- The entry struct depends on DATA_W, so it is declared inside the module, or the package gains a DATA_W constant (preferred: package constant DUMMY_DATA_W=32 as the default).
- One sub-module: dummy_tag_fifo, a generic DEPTH x width synchronous FIFO with full/empty/count. The dispatch logic wraps it.

Test Plan:
- COMB with a=5, b=7, comb_res_i=12, rsp_ready_i=1 -> rsp_valid_o the next cycle, data 12, err 0. No pipe_valid_o/iter_valid_o pulse.
- ITER request (result after 8 cycles, 0xAA) followed immediately by COMB (0x55) and PIPE (2-cycle latency, 0x33) -> responses in order 0xAA, 0x55, 0x33. pipe_res_ready_o stays 0 until 0x55 is popped.
- Illegal sel=2'b11 -> response data 0, err 1, no unit issued.
- rsp_ready_i=0 and DEPTH+1 COMB requests -> 4 accepted, req_ready_o=0 on the 5th. Then one pop per cycle drains 4 entries in order, and pointers wrap on refill.
- pipe_ready_i=0 with a PIPE request pending -> req_ready_o=0 and no push; raise pipe_ready_i -> accepted the same cycle.
- Assert rst_ni low mid-flight with 3 entries outstanding -> all outputs take their reset values immediately; after release busy_o=0 and the first new request completes normally.
